// File: rtl/conv_pkg.sv
// Shared definitions for the convolution read sequencer.
// Holds the FSM state encoding and the default pipeline drain depth.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_HOLD  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int PIPE_DEPTH_DEF = 2;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after reaching a programmable terminal count.
// Ports: clk, rst (async active-low), clr (sync zero), en, last, count, wrap.
module wrap_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Issues filter-window read addresses, handles backpressure and drains the pipeline.
// Ports: clk, rst, start, cfg_*, stall_in -> rd_en, rd_addr, stall_out, co_filter_out, done_out, busy.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [CNT_WIDTH-1:0]  cfg_filter_len,
    input  logic [CNT_WIDTH-1:0]  cfg_num_filters,
    input  logic                  stall_in,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  stall_out,
    output logic                  co_filter_out,
    output logic                  done_out,
    output logic                  busy
);

    localparam int DW = $clog2(PIPE_DEPTH + 2);

    state_t                state;
    state_t                ret_state;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  nf_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]         drain;

    logic                  issue;
    logic                  accept;
    logic [CNT_WIDTH-1:0]  elem;
    logic [CNT_WIDTH-1:0]  filt;
    logic                  elem_wrap;
    logic                  filt_wrap;
    logic                  last_issue;

    assign issue  = (state == S_RUN) && !stall_in;
    assign accept = (state == S_IDLE) && start;

    wrap_counter #(.WIDTH(CNT_WIDTH)) u_elem (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (issue),
        .last  (len_q - CNT_WIDTH'(1)),
        .count (elem),
        .wrap  (elem_wrap)
    );

    wrap_counter #(.WIDTH(CNT_WIDTH)) u_filt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (elem_wrap),
        .last  (nf_q - CNT_WIDTH'(1)),
        .count (filt),
        .wrap  (filt_wrap)
    );

    assign last_issue = elem_wrap && filt_wrap;

    // FLUSH runs PIPE_DEPTH drain cycles plus the hand-off cycle into DONE,
    // so done_out lands N+PIPE_DEPTH+1 cycles after the first issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ret_state <= S_RUN;
            len_q     <= '0;
            nf_q      <= '0;
            addr_q    <= '0;
            drain     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q  <= cfg_filter_len;
                        nf_q   <= cfg_num_filters;
                        addr_q <= cfg_base;
                        drain  <= '0;
                        if (cfg_filter_len == '0 || cfg_num_filters == '0)
                            state <= S_DONE;
                        else
                            state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stall_in) begin
                        state     <= S_HOLD;
                        ret_state <= S_RUN;
                    end else begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (last_issue) begin
                            state <= S_FLUSH;
                            drain <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_in)
                        state <= ret_state;
                end
                S_FLUSH: begin
                    if (stall_in) begin
                        state     <= S_HOLD;
                        ret_state <= S_FLUSH;
                    end else if (drain == DW'(PIPE_DEPTH)) begin
                        state <= S_DONE;
                    end else begin
                        drain <= drain + DW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en         = issue;
    assign rd_addr       = addr_q;
    assign co_filter_out = elem_wrap;
    assign stall_out     = (state == S_HOLD);
    assign done_out      = (state == S_DONE);
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomised and directed bench for conv_sequencer.
// Compares every cycle against a productive-cycle reference model.
module tb_conv_sequencer;

    localparam int PD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stall_in = 1'b0;
    logic [7:0] cfg_base = '0;
    logic [7:0] cfg_filter_len = '0;
    logic [7:0] cfg_num_filters = '0;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       stall_out;
    logic       co_filter_out;
    logic       done_out;
    logic       busy;

    conv_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_base        (cfg_base),
        .cfg_filter_len  (cfg_filter_len),
        .cfg_num_filters (cfg_num_filters),
        .stall_in        (stall_in),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .stall_out       (stall_out),
        .co_filter_out   (co_filter_out),
        .done_out        (done_out),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 active, 2 done cycle.
    // m_k counts productive active cycles: N issues then PD+1 drain cycles.
    int m_phase = 0;
    int m_k = 0;
    bit m_hold = 0;
    int m_base = 0;
    int m_len = 0;
    int m_nf = 0;
    bit m_last_rd = 0;
    int cyc = 0;
    int first_issue = -1;
    int done_cyc = -1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle(input bit st, input bit stl,
                         input int b, input int l, input int n);
        bit e_rd;
        bit e_co;
        bit e_so;
        bit e_done;
        bit e_busy;
        bit prod;
        int nn;
        e_rd = 0; e_co = 0; e_so = 0; e_done = 0; e_busy = 0; prod = 0;
        nn = m_len * m_nf;
        @(negedge clk);
        start = st;
        stall_in = stl;
        cfg_base = 8'(b);
        cfg_filter_len = 8'(l);
        cfg_num_filters = 8'(n);
        #1;
        if (m_phase == 1) begin
            e_busy = 1;
            e_so = m_hold;
            prod = !stl && !m_hold;
            e_rd = prod && (m_k < nn);
            e_co = e_rd && ((m_k % m_len) == m_len - 1);
        end else if (m_phase == 2) begin
            e_busy = 1;
            e_done = 1;
        end
        check("rd_en", int'(rd_en), int'(e_rd));
        check("co_filter_out", int'(co_filter_out), int'(e_co));
        check("stall_out", int'(stall_out), int'(e_so));
        check("done_out", int'(done_out), int'(e_done));
        check("busy", int'(busy), int'(e_busy));
        if (e_rd)
            check("rd_addr", int'(rd_addr), (m_base + m_k) % 256);
        if (rd_en && first_issue < 0)
            first_issue = cyc;
        if (done_out)
            done_cyc = cyc;
        m_last_rd = e_rd;
        case (m_phase)
            0: if (st) begin
                m_base = b; m_len = l; m_nf = n; m_k = 0; m_hold = 0;
                m_phase = (l == 0 || n == 0) ? 2 : 1;
            end
            1: begin
                if (prod) begin
                    if (m_k == nn + PD)
                        m_phase = 2;
                    m_k++;
                end
                m_hold = stl;
            end
            default: m_phase = 0;
        endcase
        cyc++;
    endtask

    // smode: 0 quiet, 1 stall 2 cycles after 2nd issue,
    // 2 random stall + junk start, 3 junk start every cycle.
    task automatic run(input int b, input int l, input int n,
                       input int smode, input int rst_at,
                       input int gap_issue, input int gap_start);
        int sc;
        int guard;
        sc = 0;
        guard = 0;
        first_issue = -1;
        done_cyc = -1;
        cyc = 0;
        cycle(1, 0, b, l, n);
        while (m_phase != 0 && guard < 3000) begin
            bit stl;
            bit st;
            stl = 0;
            st = 0;
            case (smode)
                1: if (m_phase == 1 && m_k == 2 && sc < 2) begin
                    stl = 1;
                    sc++;
                end
                2: begin
                    stl = ($urandom_range(0, 3) == 0);
                    st = ($urandom_range(0, 2) == 0);
                end
                3: st = 1;
                default: ;
            endcase
            cycle(st, stl, $urandom_range(0, 255),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            if (rst_at > 0 && m_last_rd && m_k == rst_at) begin
                #1 rst = 1'b0;
                #1;
                check("rst_rd_en", int'(rd_en), 0);
                check("rst_rd_addr", int'(rd_addr), 0);
                check("rst_stall_out", int'(stall_out), 0);
                check("rst_co", int'(co_filter_out), 0);
                check("rst_done", int'(done_out), 0);
                check("rst_busy", int'(busy), 0);
                m_phase = 0;
                @(negedge clk);
                #2 rst = 1'b1;
                break;
            end
            guard++;
        end
        if (guard >= 3000)
            check("timeout", 1, 0);
        if (gap_issue >= 0)
            check("done_after_issue", done_cyc - first_issue, gap_issue);
        if (gap_start >= 0) begin
            check("done_after_start", done_cyc, gap_start);
            check("no_rd_issue", first_issue, -1);
        end
        repeat (3) cycle(0, 0, 0, 0, 0);
        if (rst_at > 0)
            check("aborted_no_done", done_cyc, -1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done_out), 0);
        check("reset_stall_out", int'(stall_out), 0);
        #1 rst = 1'b1;

        run(8'h10, 3, 2, 0, 0, 9, -1);
        run(8'h10, 3, 2, 1, 0, -1, -1);
        run(8'h20, 0, 4, 0, 0, -1, 1);
        run(8'h30, 5, 0, 0, 0, -1, 1);
        run(8'hFE, 4, 1, 0, 0, 4 + PD + 1, -1);
        run(8'h50, 3, 2, 0, 3, -1, -1);
        run(8'h40, 2, 2, 0, 0, 4 + PD + 1, -1);
        run(8'h60, 3, 2, 3, 0, 9, -1);
        for (int i = 0; i < 25; i++)
            run($urandom_range(0, 255), $urandom_range(0, 5),
                $urandom_range(0, 4), 2, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
